// File: rtl/alarm_ctrl.sv
// Alarm sequencing controller: key handling for alarm-time setting, alarm match
// detection and the ring/snooze buzzer sequence. All outputs are registered.
module alarm_ctrl #(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   parameter int SET_TIMEOUT = 10
) (
   input  logic       clk_i,
   input  logic       cr_i,
   input  logic       sec_tick_i,
   input  logic       mode_key_i,
   input  logic       adj_key_i,
   input  logic       arm_key_i,
   input  logic [7:0] cur_hour_i,
   input  logic [7:0] cur_minute_i,
   input  logic [7:0] cur_second_i,
   input  logic [7:0] alm_hour_i,
   input  logic [7:0] alm_minute_i,
   output logic       set_en_o,
   output logic [1:0] alarm_set_select_o,
   output logic       set_confirm_o,
   output logic       armed_o,
   output logic       ringing_o,
   output logic       snoozing_o,
   output logic       buzzer_o
);

   // state      | meaning
   // S_IDLE     | waiting for keys or an armed alarm match
   // S_SET_MIN  | stepping the alarm minute field
   // S_SET_HOUR | stepping the alarm hour field
   // S_RING     | buzzer sounding, 1 s on / 1 s off
   // S_SNOOZE   | buzzer silent, counting down to ring again
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SET_MIN  = 3'd1,
      S_SET_HOUR = 3'd2,
      S_RING     = 3'd3,
      S_SNOOZE   = 3'd4
   } state_t;

   localparam logic [7:0] RING_LOAD   = 8'(RING_SECS);
   localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SECS);
   localparam logic [7:0] TMO_LOAD    = 8'(SET_TIMEOUT);

   state_t     state_q, state_d;
   logic       armed_q, armed_d;
   logic [7:0] ring_q, ring_d;
   logic [9:0] snz_q, snz_d;
   logic [7:0] tmo_q, tmo_d;
   logic       confirm_d;

   logic       set_en_q, set_en_d;
   logic [1:0] sel_q, sel_d;
   logic       confirm_q;
   logic       ringing_q, ringing_d;
   logic       snoozing_q, snoozing_d;
   logic       buzzer_q, buzzer_d;

   logic       arm_w, mode_w, adj_w, match_w;

   // Key priority: arm beats mode beats adj; losers are dropped.
   assign arm_w   = arm_key_i;
   assign mode_w  = mode_key_i & ~arm_key_i;
   assign adj_w   = adj_key_i & ~arm_key_i & ~mode_key_i;
   assign match_w = sec_tick_i && (cur_hour_i == alm_hour_i) &&
                    (cur_minute_i == alm_minute_i) && (cur_second_i == 8'h00);

   always_ff @(posedge clk_i or negedge cr_i) begin
      if (!cr_i) begin
         state_q    <= S_IDLE;
         armed_q    <= 1'b0;
         ring_q     <= '0;
         snz_q      <= '0;
         tmo_q      <= '0;
         set_en_q   <= 1'b0;
         sel_q      <= 2'b00;
         confirm_q  <= 1'b0;
         ringing_q  <= 1'b0;
         snoozing_q <= 1'b0;
         buzzer_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         armed_q    <= armed_d;
         ring_q     <= ring_d;
         snz_q      <= snz_d;
         tmo_q      <= tmo_d;
         set_en_q   <= set_en_d;
         sel_q      <= sel_d;
         confirm_q  <= confirm_d;
         ringing_q  <= ringing_d;
         snoozing_q <= snoozing_d;
         buzzer_q   <= buzzer_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      armed_d   = armed_q;
      ring_d    = ring_q;
      snz_d     = snz_q;
      tmo_d     = tmo_q;
      confirm_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (arm_w) begin
               armed_d = ~armed_q;
            end else if (mode_w) begin
               state_d = S_SET_MIN;
               tmo_d   = TMO_LOAD;
            end else if (armed_q && match_w) begin
               state_d = S_RING;
               ring_d  = RING_LOAD;
            end
         end
         S_SET_MIN, S_SET_HOUR: begin
            // arm_key is ignored here, so a tick in the same cycle still counts
            if (mode_w) begin
               state_d = (state_q == S_SET_MIN) ? S_SET_HOUR : S_IDLE;
               tmo_d   = TMO_LOAD;
            end else if (adj_w) begin
               confirm_d = 1'b1;
               tmo_d     = TMO_LOAD;
            end else if (sec_tick_i) begin
               if (tmo_q <= 8'd1) begin
                  tmo_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  tmo_d = tmo_q - 8'd1;
               end
            end
         end
         S_RING: begin
            if (arm_w) begin
               state_d = S_IDLE;
            end else if (mode_w) begin
               state_d = S_SNOOZE;
               snz_d   = SNOOZE_LOAD;
            end else if (sec_tick_i) begin
               if (ring_q <= 8'd1) begin
                  ring_d  = '0;
                  state_d = S_IDLE;
               end else begin
                  ring_d = ring_q - 8'd1;
               end
            end
         end
         S_SNOOZE: begin
            if (arm_w) begin
               state_d = S_IDLE;
            end else if (sec_tick_i) begin
               if (snz_q <= 10'd1) begin
                  snz_d   = '0;
                  state_d = S_RING;
                  ring_d  = RING_LOAD;
               end else begin
                  snz_d = snz_q - 10'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      set_en_d   = (state_d == S_SET_MIN) || (state_d == S_SET_HOUR);
      sel_d      = (state_d == S_SET_MIN)  ? 2'b01 :
                   (state_d == S_SET_HOUR) ? 2'b10 : 2'b00;
      ringing_d  = (state_d == S_RING);
      snoozing_d = (state_d == S_SNOOZE);
      if (state_d != S_RING)      buzzer_d = 1'b0;
      else if (state_q != S_RING) buzzer_d = 1'b1;
      else if (sec_tick_i)        buzzer_d = ~buzzer_q;
      else                        buzzer_d = buzzer_q;
   end

   assign set_en_o           = set_en_q;
   assign alarm_set_select_o = sel_q;
   assign set_confirm_o      = confirm_q;
   assign armed_o            = armed_q;
   assign ringing_o          = ringing_q;
   assign snoozing_o         = snoozing_q;
   assign buzzer_o           = buzzer_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: a behavioural model queues the expected outputs
// per clock, a monitor pops and compares them after each rising edge.
module tb_alarm_ctrl;

   localparam int RING_SECS   = 60;
   localparam int SNOOZE_SECS = 300;
   localparam int SET_TIMEOUT = 10;

   localparam int M_IDLE = 0, M_SMIN = 1, M_SHOUR = 2, M_RING = 3, M_SNZ = 4;

   logic       clk_i = 1'b0;
   logic       cr_i = 1'b0;
   logic       sec_tick_i = 1'b0, mode_key_i = 1'b0, adj_key_i = 1'b0, arm_key_i = 1'b0;
   logic [7:0] cur_hour_i = 8'h12, cur_minute_i = 8'h00, cur_second_i = 8'h05;
   logic [7:0] alm_hour_i = 8'h07, alm_minute_i = 8'h30;
   logic       set_en_o, set_confirm_o, armed_o, ringing_o, snoozing_o, buzzer_o;
   logic [1:0] alarm_set_select_o;

   alarm_ctrl #(
      .RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS), .SET_TIMEOUT(SET_TIMEOUT)
   ) dut (
      .clk_i(clk_i), .cr_i(cr_i), .sec_tick_i(sec_tick_i),
      .mode_key_i(mode_key_i), .adj_key_i(adj_key_i), .arm_key_i(arm_key_i),
      .cur_hour_i(cur_hour_i), .cur_minute_i(cur_minute_i), .cur_second_i(cur_second_i),
      .alm_hour_i(alm_hour_i), .alm_minute_i(alm_minute_i),
      .set_en_o(set_en_o), .alarm_set_select_o(alarm_set_select_o),
      .set_confirm_o(set_confirm_o), .armed_o(armed_o), .ringing_o(ringing_o),
      .snoozing_o(snoozing_o), .buzzer_o(buzzer_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: mode, armed flag and seconds remaining on each countdown.
   int m_mode = M_IDLE;
   bit m_armed = 0, m_buz = 0, m_conf = 0;
   int m_ring_left = 0, m_snz_left = 0, m_tmo_left = 0;

   logic [7:0] exp_q[$];

   function automatic logic [7:0] dut_vec();
      return {set_en_o, alarm_set_select_o, set_confirm_o, armed_o, ringing_o, snoozing_o, buzzer_o};
   endfunction

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (set_en,sel[1:0],confirm,armed,ringing,snoozing,buzzer) at %0t",
                    name, act, exp, $time);
   endtask

   function automatic logic [7:0] model_vec();
      bit in_set = (m_mode == M_SMIN) || (m_mode == M_SHOUR);
      logic [1:0] sel = (m_mode == M_SMIN) ? 2'b01 : (m_mode == M_SHOUR) ? 2'b10 : 2'b00;
      return {in_set, sel, m_conf, m_armed, m_mode == M_RING, m_mode == M_SNZ, m_buz};
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_armed = 0; m_buz = 0; m_conf = 0;
      m_ring_left = 0; m_snz_left = 0; m_tmo_left = 0;
   endtask

   task automatic model_step(input bit arm, input bit mode, input bit adj, input bit tick, input bit match);
      int prev = m_mode;
      m_conf = 0;
      case (m_mode)
         M_IDLE:
            if (arm) m_armed = !m_armed;
            else if (mode) begin m_mode = M_SMIN; m_tmo_left = SET_TIMEOUT; end
            else if (tick && match && m_armed) begin m_mode = M_RING; m_ring_left = RING_SECS; end
         M_SMIN, M_SHOUR: begin
            bit k_mode = mode && !arm;
            bit k_adj  = adj && !arm && !mode;
            if (k_mode) begin
               m_mode = (m_mode == M_SMIN) ? M_SHOUR : M_IDLE;
               m_tmo_left = SET_TIMEOUT;
            end else if (k_adj) begin
               m_conf = 1; m_tmo_left = SET_TIMEOUT;
            end else if (tick) begin
               if (m_tmo_left > 0) m_tmo_left--;
               if (m_tmo_left == 0) m_mode = M_IDLE;
            end
         end
         M_RING:
            if (arm) m_mode = M_IDLE;
            else if (mode) begin m_mode = M_SNZ; m_snz_left = SNOOZE_SECS; end
            else if (tick) begin
               if (m_ring_left > 0) m_ring_left--;
               if (m_ring_left == 0) m_mode = M_IDLE;
               else m_buz = !m_buz;
            end
         M_SNZ:
            if (arm) m_mode = M_IDLE;
            else if (tick) begin
               if (m_snz_left > 0) m_snz_left--;
               if (m_snz_left == 0) begin m_mode = M_RING; m_ring_left = RING_SECS; end
            end
         default: m_mode = M_IDLE;
      endcase
      if (m_mode != M_RING) m_buz = 0;
      else if (prev != M_RING) m_buz = 1;
   endtask

   // One clock of stimulus; keys and tick return to 0 after the edge.
   task automatic cycle(input bit arm, input bit mode, input bit adj, input bit tick);
      bit match;
      @(negedge clk_i);
      arm_key_i = arm; mode_key_i = mode; adj_key_i = adj; sec_tick_i = tick;
      match = (cur_hour_i == alm_hour_i) && (cur_minute_i == alm_minute_i) && (cur_second_i == 8'h00);
      model_step(arm, mode, adj, tick, match);
      exp_q.push_back(model_vec());
      @(posedge clk_i);
      #2;
      arm_key_i = 0; mode_key_i = 0; adj_key_i = 0; sec_tick_i = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 1);
   endtask

   task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      cur_hour_i = h; cur_minute_i = m; cur_second_i = s;
   endtask

   always begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) chk("scoreboard", dut_vec(), exp_q.pop_front());
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_state", dut_vec(), 8'h00);
      @(negedge clk_i);
      cr_i = 1'b1;

      // arm toggle
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);

      // set mode walk with three confirm pulses
      cycle(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin cycle(0, 0, 1, 0); cycle(0, 0, 0, 0); end
      cycle(0, 0, 1, 0); cycle(0, 0, 1, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 0);

      // set-state timeout, then timeout restarted by adj at tick 5
      cycle(0, 1, 0, 0);
      ticks(10);
      cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0);
      ticks(4);
      cycle(0, 0, 1, 1);
      ticks(10);
      cycle(0, 0, 0, 0);

      // ring at 07:30:00 for the full duration
      cycle(1, 0, 0, 0);
      set_time(8'h07, 8'h29, 8'h59); cycle(0, 0, 0, 1);
      set_time(8'h07, 8'h30, 8'h00); cycle(0, 0, 0, 1);
      set_time(8'h07, 8'h30, 8'h01);
      cycle(0, 0, 1, 0);
      ticks(RING_SECS);
      cycle(0, 0, 0, 1);

      // snooze and re-ring, then stop with arm_key
      set_time(8'h07, 8'h30, 8'h00); cycle(0, 0, 0, 1);
      set_time(8'h07, 8'h31, 8'h00);
      ticks(3);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 0);
      ticks(SNOOZE_SECS);
      ticks(2);
      cycle(1, 0, 0, 0);

      // arm + mode together in IDLE
      cycle(1, 1, 0, 0);
      cycle(1, 1, 1, 0);

      // asynchronous reset in the middle of a ring
      set_time(8'h07, 8'h30, 8'h00); cycle(0, 0, 0, 1);
      set_time(8'h12, 8'h00, 8'h05);
      ticks(2);
      #3;
      cr_i = 1'b0;
      model_reset();
      #1;
      chk("async_reset_mid_ring", dut_vec(), 8'h00);
      repeat (2) @(negedge clk_i);
      cr_i = 1'b1;

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 3) begin
            alm_hour_i   = bcd($urandom_range(0, 23));
            alm_minute_i = bcd($urandom_range(0, 59));
         end
         if ($urandom_range(0, 1) == 0) set_time(alm_hour_i, alm_minute_i, 8'h00);
         else set_time(bcd($urandom_range(0, 23)), bcd($urandom_range(0, 59)), bcd($urandom_range(0, 59)));
         cycle($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
      end

      repeat (3) @(posedge clk_i);
      #2;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
